csi2_pkt_decoder: RTL and testbench

CSI2_PKT_DECODER -- requirements
Module: csi2_pkt_decoder

---
 rtl/csi2_pkg.sv | 50 +++++
 rtl/csi2_crc16.sv | 30 +++
 rtl/csi2_pkt_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_csi2_pkt_decoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// Shared definitions for the CSI-2 packet decoder: data-type codes, the
// decoder state enum and the packet-header ECC helpers.
package csi2_pkg;

  // CSI-2 data types (DI[5:0])
  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_RAW8      = 6'h2A;
  localparam logic [5:0] DT_RAW10     = 6'h2B;
  localparam logic [5:0] DT_RGB888    = 6'h24;
  localparam logic [5:0] DT_SHORT_MAX = 6'h0F;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned WCNT_W = 15;

  typedef enum logic [2:0] {
    IDLE,
    HDR1,
    PAYLOAD,
    CRC,
    DROP
  } state_t;

  // Six ECC parity bits over the 24-bit header d = {WC_hi, WC_lo, DI}.
  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

  // Nonzero result means the received header is corrupt.
  function automatic logic [5:0] ecc_syndrome(input logic [23:0] d,
                                              input logic [5:0]  ecc);
    return ecc_calc(d) ^ ecc;
  endfunction

endpackage

// File: rtl/csi2_crc16.sv
// CSI-2 payload CRC-16: poly 0x1021 (reflected 0x8408), init 0xFFFF,
// 16 bits per cycle, data[7:0] (lane 0) consumed first, LSB first.
// Ports: clk, rst (sync, active-high), init (reload 0xFFFF), en (absorb data),
//        data[15:0] payload beat, crc[15:0] running remainder.
module csi2_crc16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] crc
);

  logic [15:0] crc_nxt;

  // Bit-serial LFSR unrolled over the 16 data bits of one beat.
  always_comb begin
    crc_nxt = crc;
    for (int i = 0; i < 16; i++) begin
      if (crc_nxt[0] ^ data[i]) crc_nxt = (crc_nxt >> 1) ^ 16'h8408;
      else                      crc_nxt = crc_nxt >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || init) crc <= 16'hFFFF;
    else if (en)     crc <= crc_nxt;
  end

endmodule

// File: rtl/csi2_pkt_decoder.sv
// CSI-2 packet decoder: parses the lane-merged 16-bit byte stream into short
// packets (frame start/end) and long packets, forwarding long-packet payload
// to an AXI-Stream output with a one-cycle registered latency.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_data/s_sot     input beats; s_data[7:0] is the earlier byte
//   m_tdata/m_tvalid/m_tready/m_tlast/m_tuser  AXI-Stream payload (tuser = SOF)
//   frame_start, frame_end   single-cycle FS/FE pulses
//   frame_num, line_cnt      last FS word count, long packets since FS
//   ecc_err/len_err/crc_err/ovf_err  sticky errors, cleared by err_clr
// Optional: define CSI2_CRC_CHECK_EN to check the payload CRC footer.
module csi2_pkt_decoder #(
  parameter int unsigned VC_ID  = 0,
  parameter int unsigned MAX_WC = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  input  logic        s_sot,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        frame_start,
  output logic        frame_end,
  output logic [15:0] frame_num,
  output logic [15:0] line_cnt,
  output logic        ecc_err,
  output logic        len_err,
  output logic        crc_err,
  output logic        ovf_err,
  input  logic        err_clr
);

  import csi2_pkg::*;

  state_t              state;
  logic [DATA_W-1:0]   hdr0;
  logic [WCNT_W-1:0]   beats_left;
  logic                sof_pend;
  logic                first_beat;

  logic [15:0] wc;
  logic [7:0]  di;
  logic [5:0]  syn;
  logic        wc_bad;
  logic        out_busy;
  logic        hdr_start;
  logic        last_beat;

  // Header decode uses the stored beat 0 plus the live beat 1.
  always_comb begin
    wc        = {s_data[7:0], hdr0[15:8]};
    di        = hdr0[7:0];
    syn       = ecc_syndrome({wc, di}, s_data[13:8]);
    wc_bad    = (wc == 16'd0) || wc[0] || (17'(wc) > 17'(MAX_WC));
    out_busy  = m_tvalid && !m_tready;
    hdr_start = s_valid && s_sot;
    last_beat = (beats_left == WCNT_W'(1));
  end

`ifdef CSI2_CRC_CHECK_EN
  logic [15:0] crc_q;
  logic        crc_init;
  logic        crc_en;

  // Reload while waiting for the header, absorb every payload beat received.
  always_comb begin
    crc_init = (state == HDR1);
    crc_en   = (state == PAYLOAD) && s_valid && !s_sot;
  end

  csi2_crc16 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (crc_init),
    .en   (crc_en),
    .data (s_data),
    .crc  (crc_q)
  );
`else
  assign crc_err = 1'b0;
`endif

  // Packet FSM with registered outputs; later assignments (error events)
  // override the err_clr clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hdr0        <= '0;
      beats_left  <= '0;
      sof_pend    <= 1'b0;
      first_beat  <= 1'b0;
      m_tdata     <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tuser     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_num   <= '0;
      line_cnt    <= '0;
      ecc_err     <= 1'b0;
      len_err     <= 1'b0;
      ovf_err     <= 1'b0;
`ifdef CSI2_CRC_CHECK_EN
      crc_err     <= 1'b0;
`endif
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      if (m_tready) m_tvalid <= 1'b0;
      if (err_clr) begin
        ecc_err <= 1'b0;
        len_err <= 1'b0;
        ovf_err <= 1'b0;
`ifdef CSI2_CRC_CHECK_EN
        crc_err <= 1'b0;
`endif
      end

      case (state)
        IDLE, DROP: begin
          if (hdr_start) begin
            hdr0  <= s_data;
            state <= HDR1;
          end
        end

        // Any valid beat here is header beat 1, regardless of s_sot.
        HDR1: begin
          if (s_valid) begin
            if (syn != 6'd0) begin
              ecc_err <= 1'b1;
              state   <= DROP;
            end else if (di[7:6] != 2'(VC_ID)) begin
              state <= DROP;
            end else if (di[5:0] <= DT_SHORT_MAX) begin
              state <= IDLE;
              if (di[5:0] == DT_FS) begin
                frame_start <= 1'b1;
                frame_num   <= wc;
                line_cnt    <= '0;
                sof_pend    <= 1'b1;
              end else if (di[5:0] == DT_FE) begin
                frame_end <= 1'b1;
              end
            end else if (wc_bad) begin
              len_err <= 1'b1;
              state   <= DROP;
            end else begin
              beats_left <= wc[15:1];
              first_beat <= sof_pend;
              sof_pend   <= 1'b0;
              state      <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (hdr_start) begin
            len_err <= 1'b1;
            hdr0    <= s_data;
            state   <= HDR1;
          end else if (s_valid) begin
            first_beat <= 1'b0;
            beats_left <= beats_left - WCNT_W'(1);
            if (last_beat) state <= CRC;
            // A stalled output register cannot take the beat; drop it.
            if (out_busy) begin
              ovf_err <= 1'b1;
            end else begin
              m_tdata  <= s_data;
              m_tvalid <= 1'b1;
              m_tlast  <= last_beat;
              m_tuser  <= first_beat;
              if (last_beat) line_cnt <= line_cnt + 16'd1;
            end
          end
        end

        CRC: begin
          if (hdr_start) begin
            len_err <= 1'b1;
            hdr0    <= s_data;
            state   <= HDR1;
          end else if (s_valid) begin
`ifdef CSI2_CRC_CHECK_EN
            if (s_data != crc_q) crc_err <= 1'b1;
`endif
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_pkt_decoder.sv
// Self-checking bench for csi2_pkt_decoder: directed scenarios followed by
// randomized packet streams, checked against a packet-level reference model.
module tb_csi2_pkt_decoder;
  import csi2_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_sot, m_tready, err_clr;
  logic [15:0] s_data;
  logic [15:0] m_tdata, frame_num, line_cnt;
  logic        m_tvalid, m_tlast, m_tuser, frame_start, frame_end;
  logic        ecc_err, len_err, crc_err, ovf_err;

  always #5 clk = ~clk;

  csi2_pkt_decoder dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_sot(s_sot),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .frame_start(frame_start),
    .frame_end(frame_end), .frame_num(frame_num), .line_cnt(line_cnt),
    .ecc_err(ecc_err), .len_err(len_err), .crc_err(crc_err),
    .ovf_err(ovf_err), .err_clr(err_clr)
  );

  // Column codes of the CSI-2 header Hamming code, one per data bit.
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  int n_chk = 0, n_bad = 0;
  int gap_pct = 0;

  // reference model state
  logic [15:0] exp_fnum = 0, exp_line = 0;
  bit exp_sof = 0, exp_ecc = 0, exp_len = 0, exp_ovf = 0, exp_crc = 0;
  bit trunc_pending = 0;
  int exp_beats = 0, exp_last = 0, exp_fs = 0, exp_fe = 0;
  int obs_beats = 0, obs_last = 0, obs_fs = 0, obs_fe = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ecc_of(input logic [23:0] d);
    logic [5:0] e = 6'd0;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
    return e;
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Observe handshakes/pulses that complete at the coming edge, then advance.
  task automatic tick();
    if (m_tvalid && m_tready) begin
      obs_beats++;
      if (m_tlast) obs_last++;
    end
    if (frame_start) obs_fs++;
    if (frame_end)   obs_fe++;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic sot, input logic [15:0] d);
    s_valid = v; s_sot = sot; s_data = d;
    tick();
    s_valid = 1'b0; s_sot = 1'b0;
  endtask

  task automatic gap();
    if ($urandom_range(99) < gap_pct) beat(1'b0, 1'($urandom), 16'($urandom));
  endtask

  task automatic junk();
    repeat ($urandom_range(0, 3)) beat(1'b1, 1'b0, 16'($urandom));
  endtask

  task automatic clear_model();
    exp_fnum = 0; exp_line = 0; exp_sof = 0; exp_ecc = 0; exp_len = 0;
    exp_ovf = 0; exp_crc = 0; trunc_pending = 0;
    exp_beats = 0; exp_last = 0; exp_fs = 0; exp_fe = 0;
    obs_beats = 0; obs_last = 0; obs_fs = 0; obs_fe = 0;
  endtask

  task automatic check_state(input string tag);
    beat(1'b0, 1'($urandom), 16'($urandom));
    beat(1'b0, 1'($urandom), 16'($urandom));
    chk({tag, "/frame_num"}, frame_num, exp_fnum);
    chk({tag, "/line_cnt"},  line_cnt,  exp_line);
    chk({tag, "/ecc_err"},   ecc_err,   exp_ecc);
    chk({tag, "/len_err"},   len_err,   exp_len);
    chk({tag, "/ovf_err"},   ovf_err,   exp_ovf);
    chk({tag, "/crc_err"},   crc_err,   exp_crc);
    chk({tag, "/beats"},     obs_beats, exp_beats);
    chk({tag, "/tlasts"},    obs_last,  exp_last);
    chk({tag, "/fs_pulses"}, obs_fs,    exp_fs);
    chk({tag, "/fe_pulses"}, obs_fe,    exp_fe);
    chk({tag, "/idle_tvalid"}, m_tvalid, 1'b0);
  endtask

  task automatic err_clear();
    err_clr = 1'b1;
    beat(1'b0, 1'b0, 16'h0);
    err_clr = 1'b0;
    exp_ecc = 0; exp_len = 0; exp_ovf = 0; exp_crc = 0;
  endtask

  // Drive one packet and update the model. trunc >= 0 cuts a long packet
  // after that many payload beats (the next packet's s_sot truncates it).
  task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt,
                          input logic [15:0] wc, input bit bad_ecc,
                          input bit bad_crc, input int trunc, input bit stall,
                          input bit seq);
    logic [7:0]  di;
    logic [5:0]  ecc;
    logic [15:0] crc, w, held;
    int nb, n;
    bit user0;
    di   = {vc, dt};
    ecc  = ecc_of({wc, di});
    held = 16'h0;
    if (bad_ecc) di[0] = ~di[0];
    if (stall) m_tready = 1'b0;
    gap(); beat(1'b1, 1'b1, {wc[7:0], di});
    if (trunc_pending) begin exp_len = 1; trunc_pending = 0; end
    gap(); beat(1'b1, 1'b0, {2'b00, ecc, wc[15:8]});
    if (bad_ecc) begin
      exp_ecc = 1; junk();
    end else if (vc != 2'd0) begin
      junk();
    end else if (dt <= 6'h0F) begin
      if (dt == 6'h00) begin exp_fs++; exp_fnum = wc; exp_line = 0; exp_sof = 1; end
      else if (dt == 6'h01) exp_fe++;
    end else if (wc == 0 || wc[0] || wc > 16'd8192) begin
      exp_len = 1; junk();
    end else begin
      nb = int'(wc) / 2;
      n  = (trunc < 0) ? nb : trunc;
      user0 = exp_sof; exp_sof = 0;
      crc = 16'hFFFF;
      for (int i = 0; i < nb; i++) begin
        w = seq ? {8'(2*i+2), 8'(2*i+1)} : 16'($urandom);
        crc = crc_byte(crc_byte(crc, w[7:0]), w[15:8]);
        if (i < n) begin
          gap(); beat(1'b1, 1'b0, w);
          if (i == 0) held = w;
          if (!stall || i == 0) begin
            exp_beats++;
            if (i == nb - 1) begin exp_line++; exp_last++; end
          end else exp_ovf = 1;
          chk("beat_tvalid", m_tvalid, 1'b1);
          chk("beat_tdata",  m_tdata, stall ? held : w);
          chk("beat_tlast",  m_tlast, stall ? (nb == 1) : (i == nb - 1));
          chk("beat_tuser",  m_tuser, user0 && (stall || i == 0));
        end
      end
      if (trunc < 0) begin
        gap(); beat(1'b1, 1'b0, bad_crc ? (crc ^ 16'h0100) : crc);
`ifdef CSI2_CRC_CHECK_EN
        if (bad_crc) exp_crc = 1;
`endif
      end else trunc_pending = 1;
    end
    m_tready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  di;
    logic [15:0] wc;
    int kind;
    rst = 1'b1; s_valid = 0; s_sot = 0; s_data = 0; m_tready = 1; err_clr = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_model();
    chk("rst/tvalid", m_tvalid, 1'b0);
    chk("rst/tdata",  m_tdata, 16'h0);
    chk("rst/tlast",  m_tlast, 1'b0);
    chk("rst/tuser",  m_tuser, 1'b0);
    check_state("rst");

    // Frame start with WC = 7
    send_pkt(2'd0, DT_FS, 16'h0007, 0, 0, -1, 0, 0);
    check_state("fs7");
    chk("fs7/frame_num_const", frame_num, 16'd7);

    // RAW8 WC = 8, payload 01..08, correct CRC
    send_pkt(2'd0, DT_RAW8, 16'd8, 0, 0, -1, 0, 1);
    check_state("raw8");
    chk("raw8/line_cnt_const", line_cnt, 16'd1);

    // Corrupted header, then a good packet
    send_pkt(2'd0, DT_RAW8, 16'd8, 1, 0, -1, 0, 0);
    check_state("ecc_bad");
    send_pkt(2'd0, DT_RAW10, 16'd6, 0, 0, -1, 0, 0);
    check_state("ecc_recover");

    // Odd WC, then a WC = 16 packet truncated by a new header
    err_clear();
    send_pkt(2'd0, DT_RAW8, 16'd5, 0, 0, -1, 0, 0);
    check_state("wc5");
    send_pkt(2'd0, DT_RAW8, 16'd16, 0, 0, 3, 0, 0);
    send_pkt(2'd0, DT_FE, 16'h0000, 0, 0, -1, 0, 0);
    check_state("trunc");

    // Stalled output during a WC = 8 packet, then clear
    send_pkt(2'd0, DT_RAW8, 16'd8, 0, 0, -1, 1, 0);
    check_state("stall");
    err_clear();
    check_state("stall_clr");

    // Wrong CRC footer, with 0 and max-accepted WC boundaries nearby
    send_pkt(2'd0, DT_RGB888, 16'd10, 0, 1, -1, 0, 0);
    check_state("bad_crc");
    send_pkt(2'd0, DT_RAW8, 16'd8194, 0, 0, -1, 0, 0);
    check_state("wc_over");
    send_pkt(2'd0, DT_RAW8, 16'd0, 0, 0, -1, 0, 0);
    check_state("wc_zero");

    // Error in the same cycle as err_clr must win
    wc = 16'd4; di = {2'd0, DT_RAW8};
    beat(1'b1, 1'b1, {wc[7:0], di ^ 8'h01});
    err_clr = 1'b1;
    beat(1'b1, 1'b0, {2'b00, ecc_of({wc, di}), wc[15:8]});
    err_clr = 1'b0;
    exp_ecc = 1; exp_len = 0; exp_ovf = 0; exp_crc = 0;
    check_state("clr_race");

    // Reset in the middle of a payload
    wc = 16'd8; di = {2'd0, DT_RAW8};
    beat(1'b1, 1'b1, {wc[7:0], di});
    beat(1'b1, 1'b0, {2'b00, ecc_of({wc, di}), wc[15:8]});
    beat(1'b1, 1'b0, 16'hBEEF);
    chk("midrst/tvalid_before", m_tvalid, 1'b1);
    rst = 1'b1;
    beat(1'b1, 1'b0, 16'hCAFE);
    chk("midrst/tvalid_after", m_tvalid, 1'b0);
    rst = 1'b0;
    clear_model();
    check_state("midrst");
    send_pkt(2'd0, DT_RAW8, 16'd4, 0, 0, -1, 0, 0);
    check_state("midrst_recover");

    // Randomized packet stream
    gap_pct = 20;
    for (int p = 0; p < 80; p++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0: send_pkt(2'd0, DT_FS, 16'($urandom), 0, 0, -1, 0, 0);
        1: send_pkt(2'd0, DT_FE, 16'($urandom), 0, 0, -1, 0, 0);
        2: send_pkt(2'd0, 6'($urandom_range(2, 15)), 16'($urandom), 0, 0, -1, 0, 0);
        3: send_pkt(2'd0, DT_RAW8, 16'(2 * $urandom_range(1, 8)), 1, 0, -1, 0, 0);
        4: send_pkt(2'($urandom_range(1, 3)), DT_RAW8, 16'(2 * $urandom_range(1, 8)), 0, 0, -1, 0, 0);
        5: begin
          case ($urandom_range(0, 2))
            0: wc = 16'd0;
            1: wc = 16'(2 * $urandom_range(0, 20) + 1);
            default: wc = 16'(2 * $urandom_range(4097, 32767));
          endcase
          send_pkt(2'd0, DT_RAW10, wc, 0, 0, -1, 0, 0);
        end
        default: begin
          wc = 16'(2 * $urandom_range(1, 12));
          send_pkt(2'd0, (kind == 6) ? DT_RGB888 : DT_RAW8, wc,
                   0, 1'($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, int'(wc) / 2)) : -1,
                   0, 0);
        end
      endcase
      if ($urandom_range(0, 9) == 0) err_clear();
      check_state("rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
